// File: rtl/effects_pkg.sv
// Shared definitions for the audio-effects datapath blocks.
package effects_pkg;

    // Sequencer states of the delay-tap datapath
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        DRAIN,
        DONE
    } dp_state_t;

    // Default sample width (ADC code) and delay buffer length
    localparam int DEFAULT_DATA_W = 12;
    localparam int DEFAULT_DEPTH  = 4096;

endpackage

// File: rtl/tap_addr_calc.sv
// Combinational read-address generator: clamps the tap delay to DEPTH-1 and
// subtracts it from the write pointer modulo DEPTH (DEPTH need not be 2^n).
module tap_addr_calc #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] i_wr_ptr,
    input  logic [ADDR_W-1:0] i_delay,
    output logic [ADDR_W-1:0] o_addr
);

    localparam logic [ADDR_W-1:0] MAX_D   = ADDR_W'(DEPTH - 1);
    // Truncation is harmless: the final result is always below DEPTH, so
    // arithmetic modulo 2^ADDR_W yields the exact address.
    localparam logic [ADDR_W-1:0] DEPTH_T = ADDR_W'(DEPTH);

    logic [ADDR_W-1:0] w_d;

    // Clamp the delay, then wrap the subtraction back into [0, DEPTH)
    always_comb begin
        w_d = (i_delay > MAX_D) ? MAX_D : i_delay;
        if (i_wr_ptr >= w_d)
            o_addr = i_wr_ptr - w_d;
        else
            o_addr = i_wr_ptr + DEPTH_T - w_d;
    end

endmodule

// File: rtl/delay_tap_engine.sv
// Delay-tap sequencer: per sample strobe, writes the sample into the external
// circular buffer, reads N_TAPS delayed samples and emits a dry+wet mix.
module delay_tap_engine
    import effects_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int N_TAPS = 2,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int MIX_W  = DATA_W + $clog2(N_TAPS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [DATA_W-1:0]          sample_in,
    input  logic [N_TAPS-1:0]          tap_en,
    input  logic [N_TAPS*ADDR_W-1:0]   tap_delay,
    input  logic                       clear_overrun,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_datain,
    input  logic [DATA_W-1:0]          mem_dataout,
    output logic [N_TAPS*DATA_W-1:0]   tap_out,
    output logic [MIX_W-1:0]           mix_out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int KW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;

    dp_state_t                 r_state;
    dp_state_t                 w_state_nxt;
    logic [KW-1:0]             r_k;
    logic [ADDR_W-1:0]         r_wr_ptr;
    logic [DATA_W-1:0]         r_sample;
    logic [N_TAPS-1:0]         r_en;
    logic [N_TAPS*ADDR_W-1:0]  r_delay;
    logic [N_TAPS*DATA_W-1:0]  r_cap;
    logic [N_TAPS*DATA_W-1:0]  w_cap_nxt;
    logic [N_TAPS*DATA_W-1:0]  r_tap_out;
    logic [MIX_W-1:0]          r_mix;
    logic                      r_valid;
    logic                      r_overrun;
    logic [ADDR_W-1:0]         w_rd_delay;
    logic [ADDR_W-1:0]         w_rd_addr;
    logic                      w_last_tap;

    // Dry sample plus all captured taps; disabled taps were captured as 0.
    // MIX_W leaves room for N_TAPS+1 full-scale terms, so no saturation.
    function automatic logic [MIX_W-1:0] mix_sum(
        input logic [DATA_W-1:0]        s,
        input logic [N_TAPS*DATA_W-1:0] taps
    );
        logic [MIX_W-1:0] acc;
        acc = MIX_W'(s);
        for (int i = 0; i < N_TAPS; i++)
            acc = acc + MIX_W'(taps[i*DATA_W +: DATA_W]);
        return acc;
    endfunction

    assign w_rd_delay = r_delay[int'(r_k)*ADDR_W +: ADDR_W];
    assign w_last_tap = (r_k == KW'(N_TAPS - 1));

    tap_addr_calc #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .i_wr_ptr (r_wr_ptr),
        .i_delay  (w_rd_delay),
        .o_addr   (w_rd_addr)
    );

    // Next-state logic; the FSM timeline is fixed regardless of tap enables
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = WRITE;
            WRITE:   w_state_nxt = READ;
            READ:    if (w_last_tap) w_state_nxt = DRAIN;
            DRAIN:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Memory-side outputs decoded from state; idle address parks on wr_ptr
    always_comb begin
        mem_write   = (r_state == WRITE);
        mem_address = (r_state == READ) ? w_rd_addr : r_wr_ptr;
        mem_datain  = r_sample;
        busy        = (r_state != IDLE);
    end

    // Read data arrives one cycle after its address: READ k>0 lands tap k-1,
    // DRAIN lands the last tap
    always_comb begin
        int idx;
        w_cap_nxt = r_cap;
        idx       = int'(r_k) - 1;
        if (r_state == READ && r_k != '0)
            w_cap_nxt[idx*DATA_W +: DATA_W] = r_en[idx] ? mem_dataout : '0;
        else if (r_state == DRAIN)
            w_cap_nxt[(N_TAPS-1)*DATA_W +: DATA_W] =
                r_en[N_TAPS-1] ? mem_dataout : '0;
    end

    // State register, tap counter and write pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == READ && !w_last_tap)
                r_k <= r_k + KW'(1);
            else
                r_k <= '0;
            if (r_state == DONE)
                r_wr_ptr <= (r_wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + ADDR_W'(1);
        end
    end

    // Per-sample snapshot of the inputs and the tap capture bank
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample <= '0;
            r_en     <= '0;
            r_delay  <= '0;
            r_cap    <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_sample <= sample_in;
                r_en     <= tap_en;
                r_delay  <= tap_delay;
            end
            r_cap <= w_cap_nxt;
        end
    end

    // Results register on the DRAIN->DONE edge so they are valid with out_valid
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tap_out <= '0;
            r_mix     <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= (r_state == DRAIN);
            if (r_state == DRAIN) begin
                r_tap_out <= w_cap_nxt;
                r_mix     <= mix_sum(r_sample, w_cap_nxt);
            end
        end
    end

    // Sticky overrun: a strobe outside IDLE sets it, and setting beats clearing
    always_ff @(posedge clk) begin
        if (reset)
            r_overrun <= 1'b0;
        else if (start && r_state != IDLE)
            r_overrun <= 1'b1;
        else if (clear_overrun)
            r_overrun <= 1'b0;
    end

    assign tap_out   = r_tap_out;
    assign mix_out   = r_mix;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_delay_tap_engine.sv
// Scoreboard bench for delay_tap_engine: instance A (DEPTH=16, 2 taps) and
// instance B (DEPTH=10, 1 tap) each drive their own synchronous-read memory.
module tb_delay_tap_engine;

    localparam int DW  = 12;
    localparam int DA  = 16;
    localparam int DB  = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- instance A ----------------
    logic            rst_a = 1'b1, a_start = 1'b0, a_clr = 1'b0;
    logic [DW-1:0]   a_sample = '0;
    logic [1:0]      a_en = '0;
    logic [7:0]      a_delay = '0;
    logic            a_mem_write, a_valid, a_busy, a_overrun;
    logic [3:0]      a_mem_address;
    logic [DW-1:0]   a_mem_datain;
    logic [DW-1:0]   a_mem_dataout = '0;
    logic [2*DW-1:0] a_tap_out;
    logic [13:0]     a_mix;
    logic [DW-1:0]   mem_a [DA] = '{default: '0};

    delay_tap_engine #(.DATA_W(DW), .DEPTH(DA), .N_TAPS(2)) dut_a (
        .clk(clk), .reset(rst_a), .start(a_start), .sample_in(a_sample),
        .tap_en(a_en), .tap_delay(a_delay), .clear_overrun(a_clr),
        .mem_write(a_mem_write), .mem_address(a_mem_address),
        .mem_datain(a_mem_datain), .mem_dataout(a_mem_dataout),
        .tap_out(a_tap_out), .mix_out(a_mix), .out_valid(a_valid),
        .busy(a_busy), .overrun(a_overrun)
    );

    always @(posedge clk) begin
        if (a_mem_write) mem_a[a_mem_address] <= a_mem_datain;
        a_mem_dataout <= mem_a[a_mem_address];
    end

    // ---------------- instance B ----------------
    logic            rst_b = 1'b1, b_start = 1'b0;
    logic [DW-1:0]   b_sample = '0;
    logic [0:0]      b_en = 1'b1;
    logic [3:0]      b_delay = '0;
    logic            b_mem_write, b_valid, b_busy, b_overrun;
    logic [3:0]      b_mem_address;
    logic [DW-1:0]   b_mem_datain;
    logic [DW-1:0]   b_mem_dataout = '0;
    logic [DW-1:0]   b_tap_out;
    logic [12:0]     b_mix;
    logic [DW-1:0]   mem_b [DB] = '{default: '0};

    delay_tap_engine #(.DATA_W(DW), .DEPTH(DB), .N_TAPS(1)) dut_b (
        .clk(clk), .reset(rst_b), .start(b_start), .sample_in(b_sample),
        .tap_en(b_en), .tap_delay(b_delay), .clear_overrun(1'b0),
        .mem_write(b_mem_write), .mem_address(b_mem_address),
        .mem_datain(b_mem_datain), .mem_dataout(b_mem_dataout),
        .tap_out(b_tap_out), .mix_out(b_mix), .out_valid(b_valid),
        .busy(b_busy), .overrun(b_overrun)
    );

    always @(posedge clk) begin
        if (b_mem_write) mem_b[b_mem_address] <= b_mem_datain;
        b_mem_dataout <= mem_b[b_mem_address];
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int          cyc;
        logic [31:0] taps;
        logic [31:0] mix;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    logic [DW-1:0] ma_mem [DA] = '{default: '0};
    logic [DW-1:0] mb_mem [DB] = '{default: '0};
    int ma_wp = 0;
    int mb_wp = 0;

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (a_valid === 1'b1) begin
            if (qa.size() == 0) chk("a_spurious_valid", 1, 0);
            else begin
                e = qa.pop_front();
                chk("a_latency", cyc, e.cyc);
                chk("a_tap_out", 32'(a_tap_out), e.taps);
                chk("a_mix", 32'(a_mix), e.mix);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (b_valid === 1'b1) begin
            if (qb.size() == 0) chk("b_spurious_valid", 1, 0);
            else begin
                e = qb.pop_front();
                chk("b_latency", cyc, e.cyc);
                chk("b_tap_out", 32'(b_tap_out), e.taps);
                chk("b_mix", 32'(b_mix), e.mix);
            end
        end
    end

    // One operation on A; inj (1..5) re-asserts start in that cycle of the op
    task automatic op_a(input int s, input logic [1:0] en, input int d0, input int d1,
                        input int inj, input logic clr_inj);
        int   dl[2];
        int   addr[2];
        int   wp0, d, v;
        exp_t e;
        @(negedge clk);
        a_start = 1'b1; a_sample = DW'(s); a_en = en;
        a_delay = {4'(d1), 4'(d0)};
        dl[0] = d0; dl[1] = d1;
        wp0 = ma_wp;
        ma_mem[wp0] = DW'(s);
        e.taps = '0; e.mix = s; e.cyc = cyc + 5;
        for (int k = 0; k < 2; k++) begin
            d = (dl[k] > DA - 1) ? DA - 1 : dl[k];
            addr[k] = (wp0 - d + DA) % DA;
            v = en[k] ? int'(ma_mem[addr[k]]) : 0;
            e.taps = e.taps | (32'(v) << (k * DW));
            e.mix = e.mix + 32'(v);
        end
        ma_wp = (wp0 + 1) % DA;
        qa.push_back(e);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            a_start = (i == inj);
            a_clr = (i == inj) && clr_inj;
            if (i == 1) begin
                chk("a_wr_en", 32'(a_mem_write), 1);
                chk("a_wr_addr", 32'(a_mem_address), 32'(wp0));
                chk("a_wr_data", 32'(a_mem_datain), 32'(s));
            end
            if (i == 2) chk("a_rd_addr0", 32'(a_mem_address), 32'(addr[0]));
            if (i == 3) chk("a_rd_addr1", 32'(a_mem_address), 32'(addr[1]));
        end
        @(negedge clk);
        a_start = 1'b0; a_clr = 1'b0;
    endtask

    task automatic op_b(input int s, input int dly);
        int   wp0, d, addr;
        exp_t e;
        @(negedge clk);
        b_start = 1'b1; b_sample = DW'(s); b_delay = 4'(dly);
        wp0 = mb_wp;
        mb_mem[wp0] = DW'(s);
        d = (dly > DB - 1) ? DB - 1 : dly;
        addr = (wp0 - d + DB) % DB;
        e.cyc = cyc + 4;
        e.taps = 32'(mb_mem[addr]);
        e.mix = 32'(s) + e.taps;
        mb_wp = (wp0 + 1) % DB;
        qb.push_back(e);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (i == 1) chk("b_wr_addr", 32'(b_mem_address), 32'(wp0));
            if (i == 2) chk("b_rd_addr", 32'(b_mem_address), 32'(addr));
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_mem_write", 32'(a_mem_write), 0);
        chk("rst_mem_address", 32'(a_mem_address), 0);
        chk("rst_mem_datain", 32'(a_mem_datain), 0);
        chk("rst_tap_out", 32'(a_tap_out), 0);
        chk("rst_mix", 32'(a_mix), 0);
        chk("rst_overrun", 32'(a_overrun), 0);
        // A strobe coincident with reset must be dropped
        a_start = 1'b1; a_sample = 12'd999;
        @(negedge clk);
        a_start = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
        chk("rst_start_dropped", 32'(a_busy), 0);

        // Basic taps: samples 1..10, then 11 with delays {0,3}
        for (int i = 1; i <= 10; i++) op_a(i, 2'b11, 0, 0, 0, 1'b0);
        op_a(11, 2'b11, 0, 3, 0, 1'b0);

        // Wrap-around: advance to wr_ptr=2 (passing 15->0), then delay 5
        while (ma_wp != 2) op_a(ma_wp * 5 + 1, 2'b11, 1, 2, 0, 1'b0);
        op_a(200, 2'b11, 5, 15, 0, 1'b0);

        // Enable mask: previous sample 50, then 100 with only tap0 enabled
        op_a(50, 2'b11, 0, 0, 0, 1'b0);
        op_a(100, 2'b01, 1, 3, 0, 1'b0);
        chk("no_false_overrun", 32'(a_overrun), 0);

        // Overrun: strobe during READ, stickiness, set-beats-clear in DONE, clear
        op_a(300, 2'b11, 2, 4, 2, 1'b0);
        chk("ovr_set", 32'(a_overrun), 1);
        op_a(301, 2'b10, 6, 1, 0, 1'b0);
        chk("ovr_sticky", 32'(a_overrun), 1);
        op_a(302, 2'b11, 0, 7, 5, 1'b1);
        chk("ovr_set_wins", 32'(a_overrun), 1);
        @(negedge clk); a_clr = 1'b1;
        @(negedge clk); a_clr = 1'b0;
        chk("ovr_clear", 32'(a_overrun), 0);

        // Random operations with full-scale samples and arbitrary delays
        for (int i = 0; i < 8; i++)
            op_a($urandom_range(0, 4095), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 15), $urandom_range(0, 15), 0, 1'b0);

        // Reset during READ: no result, wr_ptr back to 0, memory keeps the write
        @(negedge clk);
        a_start = 1'b1; a_sample = 12'd77; a_en = 2'b11; a_delay = '0;
        ma_mem[ma_wp] = 12'd77;
        ma_wp = 0;
        @(negedge clk); a_start = 1'b0;
        @(negedge clk); rst_a = 1'b1;
        @(negedge clk); rst_a = 1'b0;
        chk("midrst_busy", 32'(a_busy), 0);
        chk("midrst_valid", 32'(a_valid), 0);
        chk("midrst_mem_address", 32'(a_mem_address), 0);
        chk("midrst_tap_out", 32'(a_tap_out), 0);
        chk("midrst_mix", 32'(a_mix), 0);
        repeat (4) @(negedge clk);
        op_a(500, 2'b11, 0, 1, 0, 1'b0);

        // Instance B: delay 12 clamps to 9 on a 10-deep buffer; wraps 9->0
        for (int i = 0; i < 12; i++) op_b(i * 7 + 3, 12);
        op_b(4000, 0);
        op_b(4001, 3);

        repeat (10) @(negedge clk);
        chk("a_pending", qa.size(), 0);
        chk("b_pending", qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
